// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: IR opcode, memory handshake and per-state datapath controls.
// Latency: n/a (wires only). Backpressure: mem_ready stalls the FETCH and MEM states.
// Flow: master = control unit (drives controls), slave = datapath/memory side.
interface multicycle_control_unit_if;
    logic [4:0] opcode;
    logic       mem_ready;
    logic       resume;
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       Jump;
    logic       MemRead;
    logic [1:0] regWriteSel;
    logic       ALUSrc1;
    logic       ALUSrc2;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic       halted;
    logic       mem_err;

    modport master (
        input  opcode, mem_ready, resume,
        output state, mem_req, mem_we, iord, ir_write, pc_write, branch, Jump,
               MemRead, regWriteSel, ALUSrc1, ALUSrc2, RegWrite, ALUOp, halted, mem_err
    );

    modport slave (
        output opcode, mem_ready, resume,
        input  state, mem_req, mem_we, iord, ir_write, pc_write, branch, Jump,
               MemRead, regWriteSel, ALUSrc1, ALUSrc2, RegWrite, ALUOp, halted, mem_err
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory port.
// Latency: 2-5 cycles per instruction with mem_ready high; each wait state adds 1.
// Backpressure: FETCH and MEM hold mem_req until mem_ready; MCU_MEM_TIMEOUT_EN adds a wait limit.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    multicycle_control_unit_if.master    bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_RTYPE  = 5'b01100;
    localparam logic [4:0] OP_IARITH = 5'b00100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    // Elaboration guard: the wait counter must be able to hold the limit.
    if (2**CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_too_narrow
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t     state_q;
    logic [4:0] opc_q;
    logic       timeout_hit;

    logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_system, exec_valid;

    assign is_load    = (opc_q == OP_LOAD);
    assign is_store   = (opc_q == OP_STORE);
    assign is_branch  = (opc_q == OP_BRANCH);
    assign is_jal     = (opc_q == OP_JAL);
    assign is_jalr    = (opc_q == OP_JALR);
    assign is_lui     = (opc_q == OP_LUI);
    assign is_system  = (opc_q == OP_SYSTEM);
    assign exec_valid = is_load || is_store || is_branch || is_jal || is_jalr || is_lui ||
                        (opc_q == OP_RTYPE) || (opc_q == OP_IARITH) || (opc_q == OP_AUIPC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
        end else if (timeout_hit) begin
            state_q <= S_HALT;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        opc_q   <= bus.opcode;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_system)       state_q <= S_HALT;
                    else if (exec_valid) state_q <= S_EXEC;
                    else                 state_q <= S_FETCH;
                end
                S_EXEC: begin
                    if (is_branch || is_jal || is_jalr) state_q <= S_FETCH;
                    else if (is_load || is_store)       state_q <= S_MEM;
                    else                                state_q <= S_WB;
                end
                S_MEM: begin
                    if (bus.mem_ready) state_q <= is_store ? S_FETCH : S_WB;
                end
                S_WB: state_q <= S_FETCH;
                S_HALT: begin
                    if (bus.resume) state_q <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.state  = state_q;
    assign bus.halted = (state_q == S_HALT);

    // Controls are decoded from the current state so they are valid per state, not per instruction.
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.branch      = 1'b0;
        bus.Jump        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.regWriteSel = 2'b00;
        bus.ALUSrc1     = 1'b0;
        bus.ALUSrc2     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUOp       = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                // rst gating keeps IR/PC quiet while reset is held with memory ready.
                bus.ir_write = bus.mem_ready & rst;
                bus.pc_write = bus.mem_ready & rst;
                bus.ALUSrc1  = 1'b1;
                bus.ALUSrc2  = 1'b1;
                bus.ALUOp    = 2'b00;
            end
            S_EXEC: begin
                case (opc_q)
                    OP_RTYPE: begin
                        bus.ALUOp = 2'b10;
                    end
                    OP_IARITH: begin
                        bus.ALUOp   = 2'b10;
                        bus.ALUSrc2 = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        bus.ALUSrc2 = 1'b1;
                    end
                    OP_JALR: begin
                        bus.ALUSrc2     = 1'b1;
                        bus.Jump        = 1'b1;
                        bus.pc_write    = 1'b1;
                        bus.RegWrite    = 1'b1;
                        bus.regWriteSel = 2'b10;
                    end
                    OP_BRANCH: begin
                        bus.ALUOp  = 2'b01;
                        bus.branch = 1'b1;
                    end
                    OP_JAL: begin
                        bus.ALUSrc1     = 1'b1;
                        bus.ALUSrc2     = 1'b1;
                        bus.Jump        = 1'b1;
                        bus.pc_write    = 1'b1;
                        bus.RegWrite    = 1'b1;
                        bus.regWriteSel = 2'b10;
                    end
                    OP_AUIPC: begin
                        bus.ALUSrc1 = 1'b1;
                        bus.ALUSrc2 = 1'b1;
                    end
                    OP_LUI: begin
                        bus.ALUOp   = 2'b11;
                        bus.ALUSrc2 = 1'b1;
                    end
                    default: begin
                        bus.ALUOp = 2'b00;
                    end
                endcase
            end
            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.MemRead = is_load;
                bus.mem_we  = is_store;
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                if (is_load)     bus.regWriteSel = 2'b01;
                else if (is_lui) bus.regWriteSel = 2'b11;
                else             bus.regWriteSel = 2'b00;
            end
            default: begin
                bus.mem_req = 1'b0;
            end
        endcase
    end

`ifdef MCU_MEM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_q;
    logic             mem_err_q;

    // Any cycle without a pending wait clears the count, which covers entry to FETCH/MEM and resume.
    assign timeout_hit = bus.mem_req && !bus.mem_ready &&
                         (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else if (timeout_hit) begin
            wait_q    <= '0;
            mem_err_q <= 1'b1;
        end else if (bus.mem_req && !bus.mem_ready) begin
            wait_q <= wait_q + CNT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    assign bus.mem_err = mem_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.mem_err = 1'b0;
`endif

endmodule
